// File: rtl/rf_writeback_pkg.sv
// rf_writeback_pkg: shared register-file widths, write-back entry type and helpers.
package rf_writeback_pkg;
    localparam int REG_W = 32;
    localparam int RADDR_W = 5;
    localparam int NREG = 1 << RADDR_W;
    localparam logic [RADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [RADDR_W-1:0] addr;
        logic [REG_W-1:0]   data;
    } wb_entry_t;

    // r0 maps to an empty mask so it can never be marked pending
    function automatic logic [NREG-1:0] reg_onehot(input logic [RADDR_W-1:0] a);
        return (a == ZERO_REG) ? '0 : (NREG'(1) << a);
    endfunction
endpackage

// File: rtl/rf_writeback_wb_fifo.sv
// wb_fifo: synchronous FIFO buffering slow results until they win the RF write port.
module wb_fifo
    import rf_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  wb_entry_t i_wdata,
    output wb_entry_t o_rdata,
    output logic      o_empty,
    output logic      o_rdy
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_rdy;
    logic [AW:0]      w_count_nxt;

    assign w_count_nxt = r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
    assign o_rdata = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_rdy = r_rdy;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

    // ready is registered from the next count so it has no path from the inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_count <= '0;
            r_rdy <= 1'b1;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_rdy <= (w_count_nxt != (AW+1)'(DEPTH));
        end
    end
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: merges ALU and slow results onto the RF write port, tracks pending
// destinations and forwards the value currently on the write port.
module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ISSUE_V,
    input  logic [RADDR_W-1:0] ISSUE_ADDR,
    input  logic               ALU_V,
    input  logic [RADDR_W-1:0] ALU_ADDR,
    input  logic [REG_W-1:0]   ALU_DATA,
    input  logic               SLOW_V,
    input  logic [RADDR_W-1:0] SLOW_ADDR,
    input  logic [REG_W-1:0]   SLOW_DATA,
    output logic               SLOW_RDY,
    output logic               ALU_HOLD,
    output logic [RADDR_W-1:0] RDaddr,
    output logic [REG_W-1:0]   RD,
    input  logic [RADDR_W-1:0] RSaddr,
    input  logic [RADDR_W-1:0] RTaddr,
    output logic               RS_BUSY,
    output logic               RT_BUSY,
    output logic               RS_FWD_V,
    output logic [REG_W-1:0]   RS_FWD,
    output logic               RT_FWD_V,
    output logic [REG_W-1:0]   RT_FWD
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [RADDR_W-1:0] r_rd_addr;
    logic [REG_W-1:0]   r_rd;
    logic [NREG-1:0]    r_pending;
    logic [SW-1:0]      r_starve;
    logic               r_hold;
    logic               w_alu_v;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    wb_entry_t          w_head;
    logic [SW-1:0]      w_starve_nxt;
    logic [NREG-1:0]    w_pending_nxt;

    // ALU results to r0 are dropped before arbitration so they never block a pop
    assign w_alu_v = ALU_V && (ALU_ADDR != ZERO_REG);
    assign w_push = SLOW_V && SLOW_RDY && (SLOW_ADDR != ZERO_REG);
    assign w_pop = !w_alu_v && !w_empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(CLK),
        .rst(RESET),
        .i_push(w_push),
        .i_pop(w_pop),
        .i_wdata('{addr: SLOW_ADDR, data: SLOW_DATA}),
        .o_rdata(w_head),
        .o_empty(w_empty),
        .o_rdy(SLOW_RDY)
    );

    // the hold cycle always restarts the count, even if the ALU ignores the hold
    assign w_starve_nxt = r_hold ? '0 : (w_alu_v && !w_empty) ? r_starve + 1'b1 : '0;
    assign w_pending_nxt = (r_pending & ~reg_onehot(r_rd_addr)) | (ISSUE_V ? reg_onehot(ISSUE_ADDR) : '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rd_addr <= ZERO_REG;
            r_rd <= '0;
            r_pending <= '0;
            r_starve <= '0;
            r_hold <= 1'b0;
        end else begin
            r_rd_addr <= w_alu_v ? ALU_ADDR : w_pop ? w_head.addr : ZERO_REG;
            if (w_alu_v) r_rd <= ALU_DATA;
            else if (w_pop) r_rd <= w_head.data;
            r_pending <= w_pending_nxt;
            r_starve <= w_starve_nxt;
            r_hold <= (w_starve_nxt == SW'(STARVE_LIMIT));
        end
    end

    assign RDaddr = r_rd_addr;
    assign RD = r_rd;
    assign ALU_HOLD = r_hold;
    assign RS_FWD_V = (RSaddr == r_rd_addr) && (r_rd_addr != ZERO_REG);
    assign RT_FWD_V = (RTaddr == r_rd_addr) && (r_rd_addr != ZERO_REG);
    assign RS_FWD = r_rd;
    assign RT_FWD = r_rd;
    assign RS_BUSY = r_pending[RSaddr] && !RS_FWD_V;
    assign RT_BUSY = r_pending[RTaddr] && !RT_FWD_V;
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed scenarios for the RF write-back merger with a small rf model.
module tb_rf_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_v;
    logic [4:0]  issue_addr;
    logic        alu_v;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        slow_v;
    logic [4:0]  slow_addr;
    logic [31:0] slow_data;
    logic        slow_rdy;
    logic        alu_hold;
    logic [4:0]  rd_addr;
    logic [31:0] rd;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_busy;
    logic        rt_busy;
    logic        rs_fwd_v;
    logic [31:0] rs_fwd;
    logic        rt_fwd_v;
    logic [31:0] rt_fwd;
    logic [31:0] rf [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_writeback dut (
        .CLK(clk), .RESET(rst),
        .ISSUE_V(issue_v), .ISSUE_ADDR(issue_addr),
        .ALU_V(alu_v), .ALU_ADDR(alu_addr), .ALU_DATA(alu_data),
        .SLOW_V(slow_v), .SLOW_ADDR(slow_addr), .SLOW_DATA(slow_data),
        .SLOW_RDY(slow_rdy), .ALU_HOLD(alu_hold),
        .RDaddr(rd_addr), .RD(rd),
        .RSaddr(rs_addr), .RTaddr(rt_addr),
        .RS_BUSY(rs_busy), .RT_BUSY(rt_busy),
        .RS_FWD_V(rs_fwd_v), .RS_FWD(rs_fwd),
        .RT_FWD_V(rt_fwd_v), .RT_FWD(rt_fwd)
    );

    // rf model: latches the write port at the following edge
    always @(posedge clk) if (rd_addr != 5'd0) rf[rd_addr] <= rd;

    // protocol monitor for the stimulus itself
    always @(posedge clk) begin
        if (!rst && alu_v && alu_hold) begin
            errors++;
            $display("FAIL alu_during_hold: ALU_V=1 while ALU_HOLD=1");
        end
        if (!rst && issue_v && issue_addr != 5'd0 && dut.r_pending[issue_addr]) begin
            errors++;
            $display("FAIL issue_to_pending: issue r%0d already pending", issue_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rs_addr = 5'd5;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rdaddr: got %0d want 0", rd_addr); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd); end
        checks++; if (slow_rdy !== 1'b1) begin errors++; $display("FAIL reset_slow_rdy: got %b want 1", slow_rdy); end
        checks++; if (alu_hold !== 1'b0) begin errors++; $display("FAIL reset_alu_hold: got %b want 0", alu_hold); end
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL reset_rs_busy: got %b want 0", rs_busy); end
    endtask

    task automatic test_alu_write();
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        alu_v = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
        step();
        alu_v = 1'b0;
        #1;
        checks++; if (rd_addr !== 5'd5) begin errors++; $display("FAIL alu_rdaddr: got %0d want 5", rd_addr); end
        checks++; if (rd !== 32'h1234) begin errors++; $display("FAIL alu_rd: got %h want 1234", rd); end
        checks++; if (rs_fwd_v !== 1'b1 || rs_fwd !== 32'h1234) begin errors++; $display("FAIL alu_rs_fwd: got %b/%h want 1/1234", rs_fwd_v, rs_fwd); end
        checks++; if (rt_fwd_v !== 1'b1 || rt_fwd !== 32'h1234) begin errors++; $display("FAIL alu_rt_fwd: got %b/%h want 1/1234", rt_fwd_v, rt_fwd); end
        step();
        checks++; if (rf[5] !== 32'h1234) begin errors++; $display("FAIL alu_rf_r5: got %h want 1234", rf[5]); end
        checks++; if (rd_addr !== 5'd0 || rd !== 32'h1234) begin errors++; $display("FAIL alu_idle: got %0d/%h want 0/1234", rd_addr, rd); end
        checks++; if (rs_fwd_v !== 1'b0 || rs_busy !== 1'b0) begin errors++; $display("FAIL alu_idle_fwd: got fwd %b busy %b want 0 0", rs_fwd_v, rs_busy); end
    endtask

    task automatic test_slow_busy();
        rs_addr = 5'd7;
        rt_addr = 5'd1;
        issue_v = 1'b1; issue_addr = 5'd7;
        step();
        issue_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL slow_busy_%0d: got %b want 1", i, rs_busy); end
            if (i == 2) begin slow_v = 1'b1; slow_addr = 5'd7; slow_data = 32'hDEAD; end
            step();
        end
        slow_v = 1'b0;
        #1;
        checks++; if (rs_busy !== 1'b1 || rd_addr !== 5'd0) begin errors++; $display("FAIL slow_queued: got busy %b rdaddr %0d want 1 0", rs_busy, rd_addr); end
        step();
        checks++; if (rd_addr !== 5'd7 || rs_fwd_v !== 1'b1 || rs_fwd !== 32'hDEAD) begin errors++; $display("FAIL slow_fwd: got %0d/%b/%h want 7/1/dead", rd_addr, rs_fwd_v, rs_fwd); end
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL slow_fwd_busy: got %b want 0", rs_busy); end
        checks++; if (rt_busy !== 1'b0 || rt_fwd_v !== 1'b0) begin errors++; $display("FAIL slow_rt: got busy %b fwd %b want 0 0", rt_busy, rt_fwd_v); end
        step();
        checks++; if (rs_busy !== 1'b0 || rs_fwd_v !== 1'b0) begin errors++; $display("FAIL slow_cleared: got busy %b fwd %b want 0 0", rs_busy, rs_fwd_v); end
        checks++; if (rf[7] !== 32'hDEAD) begin errors++; $display("FAIL slow_rf_r7: got %h want dead", rf[7]); end
    endtask

    task automatic test_starve();
        for (int i = 0; i < 4; i++) begin
            alu_v = 1'b1; alu_addr = 5'd20; alu_data = 32'h5500 + i;
            slow_v = 1'b1; slow_addr = 5'(11 + i); slow_data = 32'hA0 + i;
            step();
            checks++; if (rd_addr !== 5'd20 || rd !== 32'h5500 + i) begin errors++; $display("FAIL starve_alu_%0d: got %0d/%h want 20/%h", i, rd_addr, rd, 32'h5500 + i); end
            if (i == 2) begin
                checks++; if (slow_rdy !== 1'b1 || alu_hold !== 1'b0) begin errors++; $display("FAIL starve_pre: got rdy %b hold %b want 1 0", slow_rdy, alu_hold); end
            end
        end
        alu_v = 1'b0;
        slow_v = 1'b0;
        checks++; if (slow_rdy !== 1'b0) begin errors++; $display("FAIL starve_full: got rdy %b want 0", slow_rdy); end
        checks++; if (alu_hold !== 1'b1) begin errors++; $display("FAIL starve_hold: got %b want 1", alu_hold); end
        for (int j = 0; j < 4; j++) begin
            step();
            checks++; if (rd_addr !== 5'(11 + j) || rd !== 32'hA0 + j) begin errors++; $display("FAIL starve_drain_%0d: got %0d/%h want %0d/%h", j, rd_addr, rd, 11 + j, 32'hA0 + j); end
            if (j == 0) begin
                checks++; if (alu_hold !== 1'b0 || slow_rdy !== 1'b1) begin errors++; $display("FAIL starve_release: got hold %b rdy %b want 0 1", alu_hold, slow_rdy); end
            end
        end
        step();
        checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL starve_empty: got %0d want 0", rd_addr); end
    endtask

    task automatic test_back_to_back();
        alu_v = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        slow_v = 1'b1; slow_addr = 5'd9; slow_data = 32'h99;
        step();
        alu_v = 1'b0;
        slow_v = 1'b0;
        checks++; if (rd_addr !== 5'd3 || rd !== 32'h33) begin errors++; $display("FAIL b2b_alu: got %0d/%h want 3/33", rd_addr, rd); end
        step();
        checks++; if (rd_addr !== 5'd9 || rd !== 32'h99) begin errors++; $display("FAIL b2b_slow: got %0d/%h want 9/99", rd_addr, rd); end
        slow_v = 1'b1; slow_addr = 5'd0; slow_data = 32'hBAD;
        step();
        slow_v = 1'b0;
        checks++; if (slow_rdy !== 1'b1) begin errors++; $display("FAIL r0_rdy: got %b want 1", slow_rdy); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL r0_dropped_%0d: got %0d want 0", i, rd_addr); end
        end
    endtask

    task automatic test_reset_mid();
        rs_addr = 5'd4;
        issue_v = 1'b1; issue_addr = 5'd4;
        alu_v = 1'b1; alu_addr = 5'd21; alu_data = 32'h2121;
        slow_v = 1'b1; slow_addr = 5'd15; slow_data = 32'h15;
        step();
        issue_v = 1'b0;
        slow_addr = 5'd16; slow_data = 32'h16;
        step();
        slow_v = 1'b0;
        alu_v = 1'b0;
        #1;
        checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %b want 1", rs_busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (rd_addr !== 5'd0 || slow_rdy !== 1'b1) begin errors++; $display("FAIL mid_reset: got rdaddr %0d rdy %b want 0 1", rd_addr, slow_rdy); end
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL mid_rs_busy: got %b want 0", rs_busy); end
        checks++; if (rf[21] !== 32'h2121) begin errors++; $display("FAIL mid_rf_r21: got %h want 2121", rf[21]); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL mid_no_write_%0d: got %0d want 0", i, rd_addr); end
        end
    endtask

    task automatic test_issue_on_clear();
        rs_addr = 5'd6;
        alu_v = 1'b1; alu_addr = 5'd6; alu_data = 32'h66;
        step();
        alu_v = 1'b0;
        issue_v = 1'b1; issue_addr = 5'd6;
        step();
        issue_v = 1'b0;
        #1;
        checks++; if (rs_busy !== 1'b1 || rs_fwd_v !== 1'b0) begin errors++; $display("FAIL set_wins: got busy %b fwd %b want 1 0", rs_busy, rs_fwd_v); end
        alu_v = 1'b1; alu_data = 32'h67;
        step();
        alu_v = 1'b0;
        checks++; if (rs_busy !== 1'b0 || rs_fwd_v !== 1'b1 || rs_fwd !== 32'h67) begin errors++; $display("FAIL set_wins_fwd: got %b/%b/%h want 0/1/67", rs_busy, rs_fwd_v, rs_fwd); end
        step();
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL set_wins_clear: got %b want 0", rs_busy); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst = 1'b0; issue_v = 1'b0; issue_addr = 5'd0;
        alu_v = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
        slow_v = 1'b0; slow_addr = 5'd0; slow_data = 32'd0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        test_reset();
        test_alu_write();
        test_slow_busy();
        test_starve();
        test_back_to_back();
        test_reset_mid();
        test_issue_on_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
